// File: rtl/y_cnt_pkg.sv
// Shared state encoding and default sizing for the Y-stream window counter.
package y_cnt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned WIN_LEN_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 8;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector: d is registered every cycle, rise = d & ~d_prev.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic y_q;

  always_ff @(posedge clk) begin
    if (rst) y_q <= 1'b0;
    else     y_q <= d;
  end

  assign rise = d & ~y_q;

endmodule

// File: rtl/y_window_counter.sv
// Counts rising edges of Y over fixed-length windows; publishes each window's
// saturated count with a valid/ack handshake and a sticky overrun flag.
module y_window_counter
  import y_cnt_pkg::*;
#(
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Y,
  input  logic             en,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned     WW       = $clog2(WIN_LEN);
  localparam logic [WW-1:0]   WIN_LAST = WW'(WIN_LEN - 1);

  state_t            state_q, state_d;
  logic [WW-1:0]     win_q, win_d;
  logic [CNT_W-1:0]  evt_q, evt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic              rise;
  logic              win_end;
  logic [CNT_W:0]    evt_sum;
  logic [CNT_W-1:0]  evt_sat;

  edge_rise u_edge_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (Y),
    .rise (rise)
  );

  assign evt_sum = {1'b0, evt_q} + {{CNT_W{1'b0}}, rise};
  assign evt_sat = evt_sum[CNT_W] ? '1 : evt_sum[CNT_W-1:0];
  // Dropping en on the last window cycle discards the window like any other cycle.
  assign win_end = (state_q == RUN) && en && (win_q == WIN_LAST);

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    evt_d   = evt_q;
    count_d = count_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (valid_q && ack && !win_end) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          win_d   = '0;
          evt_d   = '0;
        end else if (win_end) begin
          count_d = evt_sat;
          valid_d = 1'b1;
          if (valid_q && !ack) ovr_d = 1'b1;
          win_d   = '0;
          evt_d   = '0;
        end else begin
          win_d = win_q + WW'(1);
          evt_d = evt_sat;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      evt_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      evt_q   <= evt_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign count   = count_q;
  assign valid   = valid_q;
  assign overrun = ovr_q;
  assign busy    = (state_q == RUN);

endmodule

// File: tb/tb_y_window_counter.sv
// Bench for y_window_counter: vector table, hand sequences, random vs reference model.
module tb_y_window_counter;

  localparam int WL = 8;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, ack, Y;
  logic [CW-1:0] count;
  logic valid, overrun, busy;

  logic s_rst, s_en, s_ack, s_Y;
  logic [1:0] s_count;
  logic s_valid, s_overrun, s_busy;

  y_window_counter #(.WIN_LEN(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Y(Y), .en(en), .ack(ack),
    .count(count), .valid(valid), .overrun(overrun), .busy(busy)
  );

  y_window_counter #(.WIN_LEN(16), .CNT_W(2)) dut_s (
    .clk(clk), .rst(s_rst), .Y(s_Y), .en(s_en), .ack(s_ack),
    .count(s_count), .valid(s_valid), .overrun(s_overrun), .busy(s_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int c, input int v, input int o, input int b);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".valid"}, int'(valid), v);
    chk({tag, ".overrun"}, int'(overrun), o);
    chk({tag, ".busy"}, int'(busy), b);
  endtask

  // Reference model: window position and event tally as plain integers.
  bit m_run, m_prev_y, m_valid, m_ovr;
  int m_pos, m_evts, m_count;
  localparam int MAXC = (1 << CW) - 1;

  task automatic m_step(input bit r, input bit e, input bit a, input bit y);
    bit rise, ends, ack_clear;
    if (r) begin
      m_run = 0; m_prev_y = 0; m_valid = 0; m_ovr = 0;
      m_pos = 0; m_evts = 0; m_count = 0;
      return;
    end
    rise = y && !m_prev_y;
    ends = m_run && e && (m_pos == WL - 1);
    ack_clear = m_valid && a && !ends;
    if (m_run && e) begin
      m_evts = (m_evts + rise > MAXC) ? MAXC : m_evts + rise;
      if (ends) begin
        if (m_valid && !a) m_ovr = 1;
        m_count = m_evts; m_valid = 1; m_pos = 0; m_evts = 0;
      end else m_pos++;
    end else if (m_run) begin
      m_run = 0; m_pos = 0; m_evts = 0;
    end else if (e) m_run = 1;
    if (ack_clear) m_valid = 0;
    m_prev_y = y;
  endtask

  task automatic cyc(input bit r, input bit e, input bit a, input bit y);
    rst = r; en = e; ack = a; Y = y;
    @(posedge clk); #1;
    m_step(r, e, a, y);
  endtask

  // One full window with events on window cycles 0,2,4,6 (first n of them).
  task automatic run_window(input int n, input bit ack_last);
    for (int i = 0; i < WL; i++)
      cyc(0, 1, (i == WL - 1) && ack_last, (i % 2 == 0) && (i / 2 < n));
  endtask

  typedef struct {
    bit r, e, a, y;
    int c; bit v, o, b;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit a, bit y, int c, bit v, bit o, bit b);
    vec_t t;
    t.r = r; t.e = e; t.a = a; t.y = y; t.c = c; t.v = v; t.o = o; t.b = b;
    return t;
  endfunction

  initial begin
    rst = 1; en = 0; ack = 0; Y = 0;
    s_rst = 1; s_en = 0; s_ack = 0; s_Y = 0;

    // Pulses on window cycles 1,3,5 -> 3; then Y held 2..6 -> 1; ack behaviour.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 1, 0, i % 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 3, 0, 0, 1));
    for (int i = 2; i <= 6; i++) tbl.push_back(mk(0, 1, 0, 1, 3, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0, 0));

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].e, tbl[k].a, tbl[k].y);
      chk_out($sformatf("vec%0d", k), tbl[k].c, tbl[k].v, tbl[k].o, tbl[k].b);
    end

    // Overrun: 2 then 4 events, never acked.
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    run_window(2, 0); chk_out("ovr.w1", 2, 1, 0, 1);
    run_window(4, 0); chk_out("ovr.w2", 4, 1, 1, 1);
    cyc(0, 1, 1, 0);  chk_out("ovr.sticky", 4, 0, 1, 1);

    // Ack on the second window-end cycle: new value, valid stays, no overrun.
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    run_window(2, 0);
    run_window(4, 1); chk_out("ackend.w2", 4, 1, 0, 1);
    cyc(0, 1, 1, 0);  chk_out("ackend.clr", 4, 0, 0, 1);

    // Reset in window cycle 4 with a prior result and 2 partial events.
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    run_window(3, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0); chk_out("midrst", 0, 0, 0, 0);

    // en dropped in window cycle 4: partial discarded, next window from 0.
    cyc(1, 0, 0, 0); cyc(0, 1, 0, 0);
    run_window(1, 0);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0); chk_out("endrop", 1, 1, 0, 0);
    cyc(0, 1, 0, 0); chk_out("enrestart", 1, 1, 0, 1);
    run_window(3, 1); chk_out("enfresh", 3, 1, 0, 1);

    // Saturation: CNT_W=2, WIN_LEN=16, 6 events.
    s_rst = 1; @(posedge clk); #1;
    s_rst = 0; s_en = 1; @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      s_Y = (i % 2 == 0) && (i < 12);
      @(posedge clk); #1;
    end
    chk("sat.count", int'(s_count), 3);
    chk("sat.valid", int'(s_valid), 1);
    chk("sat.overrun", int'(s_overrun), 0);

    // Random stimulus against the reference model.
    cyc(1, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      chk_out($sformatf("rnd%0d", n), m_count, int'(m_valid), int'(m_ovr), int'(m_run));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/y_window_counter.md
Y_WINDOW_COUNTER -- requirements
Module: y_window_counter

Interface
REQ-001 Parameter WIN_LEN, default 16: window length in clk cycles, legal range 2..65535.
REQ-002 Parameter CNT_W, default 8: width of the event count.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 Y  input  1  detector output stream from the upstream sequence-detector stage (p1); synchronous to clk.
REQ-006 en  input  1  run enable; 1 = count windows, 0 = idle.
REQ-007 ack  input  1  consumer acknowledge of the current result.
REQ-008 count  output  CNT_W  event count of the last completed window.
REQ-009 valid  output  1  count holds an unacknowledged result.
REQ-010 overrun  output  1  sticky flag: a result was overwritten before it was acknowledged.
REQ-011 busy  output  1  high while in RUN.

Function
REQ-012 An event SHALL be a rising edge of Y: rise = Y & ~y_q, where y_q is Y registered every cycle regardless of state.
REQ-013 The FSM SHALL have two states: IDLE and RUN.
REQ-014 IDLE -> RUN when en=1; the cycle of the transition SHALL NOT count as a window cycle; the first window cycle is the first cycle spent in RUN.
REQ-015 RUN -> IDLE when en=0; the partial window SHALL be discarded (win_cnt=0, evt_cnt=0); count, valid and overrun are kept.
REQ-016 In RUN, each cycle SHALL increment win_cnt from 0 to WIN_LEN-1, and SHALL add rise to evt_cnt.
REQ-017 evt_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 In the RUN cycle with win_cnt==WIN_LEN-1 (window end), the block SHALL register count <= sat(evt_cnt+rise) and valid <= 1, and SHALL clear win_cnt and evt_cnt to 0; the next window starts the following cycle with no gap.
REQ-019 Result latency SHALL be one clock: count and valid update on the edge that ends the window.
REQ-020 If ack=1 and valid=1 with no window end in the same cycle, valid SHALL clear on the next edge; count SHALL hold its value.
REQ-021 If a window ends with valid=1 and ack=0, count SHALL be overwritten, valid SHALL stay 1, and overrun SHALL set.
REQ-022 If a window ends in the same cycle as ack=1, the new result SHALL be loaded, valid SHALL stay 1, and overrun SHALL NOT change.
REQ-023 ack while valid=0 SHALL be ignored.
REQ-024 An event on the window-end cycle SHALL count in the ending window, not in the next one.
REQ-025 busy SHALL equal (state==RUN).

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, win_cnt=0, evt_cnt=0, y_q=0, count=0, valid=0, overrun=0, busy=0.
REQ-027 rst SHALL override en and ack in the same cycle; reset mid-window SHALL discard the partial window.
REQ-028 overrun SHALL clear only on rst.

Structure
REQ-029 Package y_cnt_pkg SHALL hold the state encoding (IDLE=0, RUN=1) and the default WIN_LEN and CNT_W constants.
REQ-030 Rise detection SHALL be a sub-module edge_rise (clk, rst, d, rise) instantiated once.
REQ-031 win_cnt width SHALL be $clog2(WIN_LEN).

Verification (WIN_LEN=8, CNT_W=8 unless stated)
REQ-032 rst, en=1, single-cycle Y pulses on window cycles 1, 3 and 5 -> after window cycle 7: valid=1, count=3, overrun=0.
REQ-033 Y held high for window cycles 2..6 -> count=1 (one edge).
REQ-034 Two full windows with 2 and then 4 events, ack=0 throughout -> after the second window: count=4, valid=1, overrun=1.
REQ-035 ack=1 asserted on the second window-end cycle -> count=new value, valid=1, overrun=0; ack=1 on the next cycle -> valid=0.
REQ-036 CNT_W=2, WIN_LEN=16, 6 events -> count=3 (saturated).
REQ-037 rst pulse in window cycle 4 with 2 events already counted -> all outputs 0 next cycle; en=0 in window cycle 4 -> busy=0, and the next window after en=1 counts from 0.
